sdu_debug_hub: RTL
==================

# sdu_debug_hub

- Parametrised run-control and probe-capture hub between the CPU test harness and the serial debug unit.
- Drives the CPU clock enable in halt, step and run modes, and supports `NBP` programmable PC breakpoints.
- Freezes a snapshot of `NCH` probe channels (pipeline registers, control words) whenever the CPU stops.
- Serves snapshot, cycle count and status through a registered read port.

## Interface

Parameters:
- `W`, 32, probe / PC / argument width
- `NCH`, 19, number of probe channels
- `NBP`, 4, number of breakpoint slots (≥1)
- `CNTW`, 32, cycle counter width (≤ W)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `probe_i`  in  NCH*W  probe channels; channel k = bits [k*W +: W]
- `pc_chk`  in  W  PC of the instruction that executes on the next enabled edge
- `cmd_valid`  in  1  host command strobe
- `cmd_ready`  out  1  constant 1; a command is taken on any cycle with `cmd_valid`=1
- `cmd_op`  in  3  0 NOP, 1 STEP, 2 RUN, 3 HALT, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT
- `cmd_idx`  in  clog2(NBP) (min 1)  breakpoint slot
- `cmd_arg`  in  W  STEP count or breakpoint address
- `cpu_ce`  out  1  CPU clock enable (combinational)
- `halted`  out  1  state == HALT
- `rd_sel`  in  clog2(NCH+2)  read select
- `rd_data`  out  W  registered read data
- `err`  out  1  sticky: non-HALT/NOP command received while not halted

## Operation

- **States:** HALT, RUN, STEP, SNAP.
- **HALT:**
  - STEP goes to STEP and loads the step counter with `cmd_arg`; an arg of 0 is treated as 1.
  - RUN goes to RUN and sets the `first` flag.
  - SET_BP writes `bp_addr[idx]`=arg and sets `bp_en[idx]`=1.
  - CLR_BP clears `bp_en[idx]`.
  - CLR_CNT zeroes `cycle_cnt`.
  - HALT and NOP are no-ops.
- **RUN:**
  - `hit` = OR over slots of `bp_en[i] && pc_chk==bp_addr[i]`.
  - `cpu_ce` = !(hit && !first). `first` clears after the first RUN cycle, so the CPU resumes past a breakpoint it is stopped on.
  - If hit && !first: go to SNAP, cause=3, and do not execute that instruction.
  - Else, if a HALT command arrives: `cpu_ce`=1 that cycle, then SNAP with cause=1.
- **STEP:**
  - `cpu_ce`=1 for exactly n cycles; breakpoints are ignored.
  - After the last step cycle go to SNAP with cause=2.
  - A HALT command ends STEP early after the current cycle, with cause=1.
- **SNAP:** one cycle, `cpu_ce`=0. All `probe_i` are copied into the snapshot bank and `stop_cause` is latched. Then go to HALT.
- **Commands while not halted:** any command other than HALT or NOP is dropped and sets `err`. `err` clears only on `rst`.
- **Cycle counter:** `cycle_cnt` increments on every cycle with `cpu_ce`=1 and wraps modulo 2^CNTW. CLR_CNT is valid only in HALT.
- **Read map (`rd_sel`):**
  - `<NCH`: snapshot[sel].
  - `NCH`: `cycle_cnt`, zero-extended.
  - `NCH+1`: status {0…, stop_cause[1:0], err, halted}.
  - Anything else: 0.
- **Reset values:**
  - State HALT, `cpu_ce`=0, `halted`=1, `err`=0.
  - `stop_cause`=0, `cycle_cnt`=0, snapshots=0.
  - `bp_en`=0, `bp_addr`=0, `rd_data`=0.

## Timing

- `cpu_ce` is combinational from state, `hit` and `first`, and is forced to 0 while `rst`=1.
- Stop latency:
  - HALT command in RUN: exactly one more enabled cycle, then SNAP, then `halted`=1 two edges after command acceptance.
  - Breakpoint: `cpu_ce`=0 in the hit cycle itself; SNAP occupies the next cycle.
- The snapshot samples `probe_i` in the SNAP cycle, i.e. the state after the last enabled edge.
- Read latency is 1 cycle: `rd_data` at edge t+1 reflects `rd_sel` at t.
- **Simultaneous events:**
  - Breakpoint hit together with a HALT command: cause=3 and `cpu_ce`=0.
  - SET_BP and CLR_BP on the same slot cannot coincide (one command per cycle).
  - Breakpoint on the last STEP cycle is ignored.
- `rst` mid-RUN or mid-STEP: state returns to HALT on the next edge with no SNAP; all reset values apply.

## Structure

- Package `sdu_debug_pkg`:
  - opcode localparams
  - state enum {HALT, RUN, STEP, SNAP}
  - cause codes {0 reset, 1 host, 2 step, 3 breakpoint}
- Sub-module `sdu_bp_match`:
  - holds the `NBP` slot registers
  - comparators plus OR-reduce producing `hit`
  - write and clear ports for slot updates
- Top block holds the FSM, step counter, cycle counter, snapshot bank and read mux.

## Test plan

- Reset, then read `rd_sel`=NCH+1: expect 0x1 (halted, cause 0); `cpu_ce`=0.
- STEP arg=3 from HALT: `cpu_ce` high exactly 3 cycles; read NCH → 3; status cause=2; snapshot ch0 equals `probe_i` ch0 in the SNAP cycle.
- SET_BP idx0=0x0000_0010, RUN, with `pc_chk` ramping 0x0,0x4,…: `cpu_ce` drops when `pc_chk`=0x10; cause=3. A second RUN executes the 0x10 cycle and continues.
- RUN, then HALT command at cycle k: exactly k+1 enabled cycles counted; cause=1. A STEP issued while running sets `err`=1 and is ignored.
- `CNTW`=4 instance: STEP 17 → count reads 1 (wrap).
- `rst` asserted mid-RUN: `cpu_ce`=0 in the same cycle; afterwards all reset values are restored and breakpoints are cleared.

Source files
------------

// File: rtl/sdu_debug_pkg.sv
// sdu_debug_pkg: opcodes, FSM states and stop causes shared by the debug hub
package sdu_debug_pkg;
   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_STEP    = 3'd1;
   localparam logic [2:0] OP_RUN     = 3'd2;
   localparam logic [2:0] OP_HALT    = 3'd3;
   localparam logic [2:0] OP_SET_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_BP  = 3'd5;
   localparam logic [2:0] OP_CLR_CNT = 3'd6;
   typedef enum logic [1:0] {HALT, RUN, STEP, SNAP} state_t;
   typedef enum logic [1:0] {CAUSE_RESET, CAUSE_HOST, CAUSE_STEP, CAUSE_BP} cause_t;
endpackage

// File: rtl/sdu_bp_match.sv
// sdu_bp_match: breakpoint slot registers and PC comparators producing hit
module sdu_bp_match #(
   parameter int W   = 32,
   parameter int NBP = 4,
   parameter int IW  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic          clr,
   input  logic [IW-1:0] idx,
   input  logic [W-1:0]  addr,
   input  logic [W-1:0]  pc,
   output logic          hit
);
   logic [W-1:0]   bp_addr [NBP];
   logic [NBP-1:0] bp_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         bp_en <= '0;
         for (int i = 0; i < NBP; i++) bp_addr[i] <= '0;
      end else begin
         for (int i = 0; i < NBP; i++) begin
            if (wr && idx == IW'(i)) begin
               bp_addr[i] <= addr;
               bp_en[i]   <= 1'b1;
            end
            if (clr && idx == IW'(i)) bp_en[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NBP; i++) hit = hit | (bp_en[i] && pc == bp_addr[i]);
   end
endmodule

// File: rtl/sdu_debug_hub.sv
// sdu_debug_hub: CPU run control (halt/step/run/breakpoints) with stop-time probe snapshot and read port
module sdu_debug_hub
   import sdu_debug_pkg::*;
#(
   parameter int W    = 32,
   parameter int NCH  = 19,
   parameter int NBP  = 4,
   parameter int CNTW = 32,
   localparam int IW  = NBP > 1 ? $clog2(NBP) : 1,
   localparam int SW  = $clog2(NCH + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] probe_i,
   input  logic [W-1:0]     pc_chk,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [IW-1:0]    cmd_idx,
   input  logic [W-1:0]     cmd_arg,
   output logic             cpu_ce,
   output logic             halted,
   input  logic [SW-1:0]    rd_sel,
   output logic [W-1:0]     rd_data,
   output logic             err
);
   state_t          state;
   cause_t          pend, stop_cause;
   logic            first, hit, host_halt, bad_cmd, bp_wr, bp_clr;
   logic [W-1:0]    step_cnt, status, rd_mux;
   logic [CNTW-1:0] cycle_cnt;
   logic [W-1:0]    snap [NCH];

   assign cmd_ready = 1'b1;
   assign halted    = state == HALT;
   assign host_halt = cmd_valid && cmd_op == OP_HALT;
   assign bad_cmd   = cmd_valid && !halted && cmd_op != OP_HALT && cmd_op != OP_NOP;
   assign bp_wr     = cmd_valid && halted && cmd_op == OP_SET_BP;
   assign bp_clr    = cmd_valid && halted && cmd_op == OP_CLR_BP;
   // first lets RUN resume past the breakpoint the CPU is currently parked on
   assign cpu_ce    = !rst && (state == STEP || (state == RUN && !(hit && !first)));
   assign status    = {{(W-4){1'b0}}, stop_cause, err, halted};

   sdu_bp_match #(.W(W), .NBP(NBP), .IW(IW)) u_bp (
      .clk  (clk),
      .rst  (rst),
      .wr   (bp_wr),
      .clr  (bp_clr),
      .idx  (cmd_idx),
      .addr (cmd_arg),
      .pc   (pc_chk),
      .hit  (hit)
   );

   always_comb
      rd_mux = int'(rd_sel) < NCH ? snap[rd_sel] :
               int'(rd_sel) == NCH ? W'(cycle_cnt) :
               int'(rd_sel) == NCH + 1 ? status : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HALT;
         pend       <= CAUSE_RESET;
         stop_cause <= CAUSE_RESET;
         first      <= 1'b0;
         err        <= 1'b0;
         step_cnt   <= '0;
         cycle_cnt  <= '0;
         rd_data    <= '0;
         for (int k = 0; k < NCH; k++) snap[k] <= '0;
      end else begin
         rd_data <= rd_mux;
         if (cpu_ce) cycle_cnt <= cycle_cnt + 1'b1;
         if (bad_cmd) err <= 1'b1;
         case (state)
            HALT: begin
               if (cmd_valid && cmd_op == OP_STEP) begin
                  state    <= STEP;
                  step_cnt <= cmd_arg == '0 ? W'(1) : cmd_arg;
               end
               if (cmd_valid && cmd_op == OP_RUN) begin
                  state <= RUN;
                  first <= 1'b1;
               end
               if (cmd_valid && cmd_op == OP_CLR_CNT) cycle_cnt <= '0;
            end
            RUN: begin
               first <= 1'b0;
               if (hit && !first) begin
                  state <= SNAP;
                  pend  <= CAUSE_BP;
               end else if (host_halt) begin
                  state <= SNAP;
                  pend  <= CAUSE_HOST;
               end
            end
            STEP: begin
               step_cnt <= step_cnt - 1'b1;
               if (step_cnt == W'(1)) begin
                  state <= SNAP;
                  pend  <= CAUSE_STEP;
               end else if (host_halt) begin
                  state <= SNAP;
                  pend  <= CAUSE_HOST;
               end
            end
            default: begin
               for (int k = 0; k < NCH; k++) snap[k] <= probe_i[k*W +: W];
               stop_cause <= pend;
               state      <= HALT;
            end
         endcase
      end
   end
endmodule
